// File: rtl/ntsc_write_if.sv
// ntsc_write_if: pixel-stream input and memory write handshake bundle.
// drop_count is present only when NTSC_WRITE_DROP_COUNT_EN is defined.
interface ntsc_write_if;
   logic        pix_valid;
   logic [7:0]  pix_y;
   logic [7:0]  pix_cb;
   logic [7:0]  pix_cr;
   logic        line_start;
   logic        frame_start;
   logic        ntsc_flag;
   logic [35:0] ntsc_pixel;
   logic        done_ntsc;
   logic        new_frame;
   logic        overflow;
`ifdef NTSC_WRITE_DROP_COUNT_EN
   logic [15:0] drop_count;
`endif
   modport slave (
      input  pix_valid, pix_y, pix_cb, pix_cr, line_start, frame_start, done_ntsc,
      output ntsc_flag, ntsc_pixel, new_frame, overflow
`ifdef NTSC_WRITE_DROP_COUNT_EN
      , drop_count
`endif
   );
   modport master (
      output pix_valid, pix_y, pix_cb, pix_cr, line_start, frame_start, done_ntsc,
      input  ntsc_flag, ntsc_pixel, new_frame, overflow
`ifdef NTSC_WRITE_DROP_COUNT_EN
      , drop_count
`endif
   );
endinterface

// File: rtl/ntsc_write.sv
// ntsc_write: crops a YCbCr stream, packs two 18-bit pixels per word, buffers and writes them out.
// Optional NTSC_WRITE_DROP_COUNT_EN adds a saturating count of words dropped on a full FIFO.
module ntsc_write #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int FIFO_DEPTH = 4
) (
   input logic         clock,
   input logic         reset,
   ntsc_write_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic {IDLE, REQ} state_t;
   state_t        state_q, state_d;
   logic [10:0]   x_q, x_d, cur_x;
   logic [9:0]    y_q, y_d, cur_y;
   logic [17:0]   upper_q, upper_d, p;
   logic          half_q, half_d, push_q, push_d;
   logic [35:0]   word_q, word_d;
   logic [35:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          pend_q, pend_d, ovf_q, ovf_d;
   logic          fs, ls, in_win, pop, full, drop, wr_en, keep, new_frame;
   assign fs        = bus.pix_valid & bus.frame_start;
   assign ls        = bus.pix_valid & bus.line_start & ~bus.frame_start;
   assign cur_x     = (fs | ls) ? '0 : x_q;
   assign cur_y     = fs ? '0 : ls ? ((y_q == '1) ? y_q : y_q + 10'd1) : y_q;
   assign in_win    = int'(cur_x) < H_ACTIVE && int'(cur_y) < V_ACTIVE;
   assign p         = {bus.pix_y[7:2], bus.pix_cb[7:2], bus.pix_cr[7:2]};
   assign pop       = (state_q == REQ) & bus.done_ntsc;
   assign full      = cnt_q == (AW+1)'(FIFO_DEPTH);
   // The in-flight word at a frame_start belongs to the old frame, so it is discarded rather than pushed.
   assign drop      = push_q & ~fs & full & ~pop;
   assign wr_en     = push_q & ~fs & (~full | pop);
   assign keep      = (state_q == REQ) & ~pop;
   assign new_frame = pend_q & (state_q == IDLE);
   assign bus.new_frame  = new_frame;
   assign bus.overflow   = ovf_q;
   assign bus.ntsc_flag  = state_q == REQ;
   assign bus.ntsc_pixel = (state_q == REQ) ? mem[rd_q] : '0;
   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      upper_d = upper_q;
      half_d  = half_q & ~(fs | ls);
      push_d  = 1'b0;
      word_d  = word_q;
      if (bus.pix_valid) begin
         x_d = (cur_x == '1) ? cur_x : cur_x + 11'd1;
         y_d = cur_y;
         if (in_win && !cur_x[0]) begin
            upper_d = p;
            half_d  = 1'b1;
         end else if (in_win && half_q) begin
            push_d = 1'b1;
            word_d = {upper_q, p};
            half_d = 1'b0;
         end
      end
   end
   always_comb begin
      rd_d  = rd_q + AW'(pop);
      wr_d  = wr_q + AW'(wr_en);
      cnt_d = cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
      if (fs) begin
         wr_d  = rd_d + AW'(keep);
         cnt_d = (AW+1)'(keep);
      end
      pend_d  = fs | (pend_q & ~new_frame);
      ovf_d   = ~fs & (ovf_q | drop);
      state_d = pop ? IDLE : (state_q == IDLE && cnt_q != '0 && !pend_q && !fs) ? REQ : state_q;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         upper_q <= '0;
         half_q  <= 1'b0;
         push_q  <= 1'b0;
         word_q  <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         upper_q <= upper_d;
         half_q  <= half_d;
         push_q  <= push_d;
         word_q  <= word_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
      end
   always_ff @(posedge clock)
      if (wr_en) mem[wr_q] <= word_q;
`ifdef NTSC_WRITE_DROP_COUNT_EN
   logic [15:0] drops_q, drops_d;
   assign drops_d = fs ? '0 : drops_q + 16'(drop & (drops_q != '1));
   assign bus.drop_count = drops_q;
   always_ff @(posedge clock or posedge reset)
      if (reset) drops_q <= '0;
      else drops_q <= drops_d;
`endif
endmodule
